// File: rtl/trig_burst_gen_pkg.sv
// Shared definitions for the trigger burst sequencer: FSM state encoding and
// default widths reused by the host register map.
package trig_burst_gen_pkg;

  localparam int TBG_CNT_W = 16;
  localparam int TBG_NUM_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'h0,
    DELAY = 2'h1,
    PULSE = 2'h2,
    GAP   = 2'h3
  } state_e;

endpackage

// File: rtl/trig_down_counter.sv
// Loadable down-counter that parks at zero; tc_o flags the terminal count.
module trig_down_counter #(
  parameter int W = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         en_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/trig_burst_gen.sv
// Fast-clock trigger sequencer: after a start, waits a delay and then emits a
// burst of one-cycle trigger pulses at a fixed period. All outputs registered.
module trig_burst_gen
  import trig_burst_gen_pkg::*;
#(
  parameter int CNT_W = TBG_CNT_W,
  parameter int NUM_W = TBG_NUM_W
) (
  input  logic             wClk_i,
  input  logic             wReset_i,
  input  logic             wStart_i,
  input  logic             wAbort_i,
  input  logic [CNT_W-1:0] wDelay_i,
  input  logic [CNT_W-1:0] wPeriod_i,
  input  logic [NUM_W-1:0] wCount_i,
  output logic             wTrig_o,
  output logic             wBusy_o,
  output logic             wDone_o,
  output logic [NUM_W-1:0] wPulseIdx_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [NUM_W-1:0] count_q, count_d;
  logic [NUM_W-1:0] idx_q, idx_d;
  logic             trig_q, trig_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             tmr_load, tmr_en, tmr_tc;
  logic [CNT_W-1:0] tmr_load_val;

  // One shared timer covers both the start delay and the inter-pulse gap.
  trig_down_counter #(.W(CNT_W)) u_tmr (
    .clk_i      (wClk_i),
    .rst_i      (wReset_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .en_i       (tmr_en),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d      = state_q;
    period_d     = period_q;
    count_d      = count_q;
    idx_d        = idx_q;
    done_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;

    if (wAbort_i) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (wStart_i) begin
            period_d = (wPeriod_i == '0) ? CNT_W'(1) : wPeriod_i;
            count_d  = wCount_i;
            idx_d    = '0;
            if (wCount_i == '0) begin
              done_d = 1'b1;
            end else if (wDelay_i == '0) begin
              // Zero delay puts the first pulse directly in cycle 1.
              state_d = PULSE;
              idx_d   = NUM_W'(1);
            end else begin
              state_d      = DELAY;
              tmr_load     = 1'b1;
              tmr_load_val = wDelay_i - CNT_W'(1);
            end
          end
        end
        DELAY, GAP: begin
          if (tmr_tc) begin
            state_d = PULSE;
            idx_d   = idx_q + NUM_W'(1);
          end else begin
            tmr_en = 1'b1;
          end
        end
        PULSE: begin
          if (idx_q == count_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else if (period_q == CNT_W'(1)) begin
            idx_d = idx_q + NUM_W'(1);
          end else begin
            // Gap spans period-1 cycles, so the timer counts period-2 down to 0.
            state_d      = GAP;
            tmr_load     = 1'b1;
            tmr_load_val = period_q - CNT_W'(2);
          end
        end
        default: state_d = IDLE;
      endcase
    end

    trig_d = (state_d == PULSE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge wClk_i) begin
    if (wReset_i) begin
      state_q  <= IDLE;
      period_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      trig_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      trig_q   <= trig_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign wTrig_o     = trig_q;
  assign wBusy_o     = busy_q;
  assign wDone_o     = done_q;
  assign wPulseIdx_o = idx_q;

endmodule
